// File: rtl/alu_sequencer_pkg.sv
// Shared encodings for the ALU sequencer: operation codes, FSM states and
// small decode helpers used by both the sequencing and the output decode.
package alu_sequencer_pkg;

  localparam logic [1:0] OP_ADD_C = 2'b00;
  localparam logic [1:0] OP_SUB_C = 2'b01;
  localparam logic [1:0] OP_SHL_C = 2'b10;
  localparam logic [1:0] OP_CMP_C = 2'b11;

  localparam logic [2:0] ST_IDLE_C   = 3'd0;
  localparam logic [2:0] ST_LOAD_A_C = 3'd1;
  localparam logic [2:0] ST_LOAD_B_C = 3'd2;
  localparam logic [2:0] ST_EXEC_C   = 3'd3;
  localparam logic [2:0] ST_WRITE_C  = 3'd4;

  typedef enum logic [1:0] {
    OP_ADD = OP_ADD_C,
    OP_SUB = OP_SUB_C,
    OP_SHL = OP_SHL_C,
    OP_CMP = OP_CMP_C
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = ST_IDLE_C,
    ST_LOAD_A = ST_LOAD_A_C,
    ST_LOAD_B = ST_LOAD_B_C,
    ST_EXEC   = ST_EXEC_C,
    ST_WRITE  = ST_WRITE_C
  } state_e;

  // SHL operates on A alone; every other op needs the B operand loaded.
  function automatic logic needs_b(input op_e op);
    return op != OP_SHL;
  endfunction

  // SUB and CMP both run the ALU in subtract mode; CMP just discards the result.
  function automatic logic uses_sub(input op_e op);
    return (op == OP_SUB) || (op == OP_CMP);
  endfunction

  function automatic logic writes_dst(input op_e op);
    return op != OP_CMP;
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Moore control sequencer for a bus-based ALU: loads operands from the shared
// bus, runs one ADD/SUB/SHL/CMP, writes the result back and captures flags.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [2:0]       shamt,
  input  logic             alu_carry,
  input  logic [WIDTH-1:0] bus_in,
  output logic             src_a_oe,
  output logic             src_b_oe,
  output logic             rega_write_enable,
  output logic             regb_write_enable,
  output logic             sub_enable,
  output logic             shift_enable,
  output logic [2:0]       shift_pos,
  output logic             alu_enable,
  output logic             dst_we,
  output logic             busy,
  output logic             done,
  output logic             carry_flag,
  output logic             zero_flag
);

  state_e     state_q, state_d;
  op_e        op_q;
  logic [2:0] shamt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_ADD;
      shamt_q    <= '0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        op_q    <= op_e'(op);
        shamt_q <= shamt;
      end
      // The result is on the bus throughout WRITE, so flags capture at its end.
      if (state_q == ST_WRITE) begin
        carry_flag <= alu_carry;
        zero_flag  <= (bus_in == '0);
      end
    end
  end

  // NOTE: every signal driven here gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d           = state_q;
    src_a_oe          = 1'b0;
    src_b_oe          = 1'b0;
    rega_write_enable = 1'b0;
    regb_write_enable = 1'b0;
    sub_enable        = 1'b0;
    shift_enable      = 1'b0;
    shift_pos         = 3'd0;
    alu_enable        = 1'b0;
    dst_we            = 1'b0;
    busy              = 1'b1;
    done              = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_d = ST_LOAD_A;
      end
      ST_LOAD_A: begin
        src_a_oe          = 1'b1;
        rega_write_enable = 1'b1;
        state_d           = needs_b(op_q) ? ST_LOAD_B : ST_EXEC;
      end
      ST_LOAD_B: begin
        src_b_oe          = 1'b1;
        regb_write_enable = 1'b1;
        state_d           = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        alu_enable = 1'b1;
        done       = 1'b1;
        dst_we     = writes_dst(op_q);
        state_d    = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // Operation select stays stable across EXEC and WRITE so the ALU output
    // does not change while it is being driven onto the bus.
    if (state_q == ST_EXEC || state_q == ST_WRITE) begin
      sub_enable = uses_sub(op_q);
      if (op_q == OP_SHL) begin
        shift_enable = 1'b1;
        shift_pos    = shamt_q;
      end
    end
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter: WIDTH, 8, data bus width (matches the ALU datapath).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request one ALU operation; sampled only in IDLE.
REQ-005 SHALL have port: op  input  2  operation: 00 ADD, 01 SUB, 10 SHL, 11 CMP; sampled with start.
REQ-006 SHALL have port: shamt  input  3  shift amount for SHL; sampled with start.
REQ-007 SHALL have port: alu_carry  input  1  ALU carry_out.
REQ-008 SHALL have port: bus_in  input  WIDTH  shared data bus, used for zero-flag capture.
REQ-009 SHALL have port: src_a_oe  output  1  drive operand A source onto bus.
REQ-010 SHALL have port: src_b_oe  output  1  drive operand B source onto bus.
REQ-011 SHALL have port: rega_write_enable / regb_write_enable  output  1 each  ALU operand register loads.
REQ-012 SHALL have port: sub_enable / shift_enable  output  1 each  ALU operation select.
REQ-013 SHALL have port: shift_pos  output  3  ALU shift amount.
REQ-014 SHALL have port: alu_enable  output  1  ALU result onto bus.
REQ-015 SHALL have port: dst_we  output  1  destination register write strobe.
REQ-016 SHALL have port: busy, done, carry_flag, zero_flag  output  1 each  status.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD_A, LOAD_B, EXEC, WRITE; all control outputs are registered-state decodes (Moore), no combinational path from start.
REQ-018 SHALL, in IDLE with start=1, latch op/shamt and go to LOAD_A next cycle; start=0 stays IDLE.
REQ-019 SHALL ignore start whenever state != IDLE (no queuing).
REQ-020 SHALL assert src_a_oe and rega_write_enable for exactly the LOAD_A cycle.
REQ-021 SHALL go LOAD_A -> LOAD_B for ADD/SUB/CMP and LOAD_A -> EXEC for SHL.
REQ-022 SHALL assert src_b_oe and regb_write_enable for exactly the LOAD_B cycle; LOAD_B -> EXEC.
REQ-023 SHALL hold sub_enable=1 (SUB, CMP) or shift_enable=1 with shift_pos=latched shamt (SHL) during EXEC and WRITE; 0 otherwise.
REQ-024 SHALL go EXEC -> WRITE unconditionally (ALU result register settles at end of EXEC).
REQ-025 SHALL in WRITE assert alu_enable and done for one cycle; dst_we=1 except for CMP (dst_we=0).
REQ-026 SHALL at end of WRITE load carry_flag<=alu_carry and zero_flag<=(bus_in==0) for all ops; flags hold otherwise.
REQ-027 SHALL go WRITE -> IDLE; a start in the following IDLE cycle is accepted (back-to-back issue).
REQ-028 SHALL assert busy in every state except IDLE.
REQ-029 SHALL never assert rega_write_enable and regb_write_enable, or any two of src_a_oe/src_b_oe/alu_enable, in the same cycle.
REQ-030 SHALL give latency start-to-done of 4 cycles (ADD/SUB/CMP) and 3 cycles (SHL).

Reset
REQ-031 SHALL on rst=1 at a clock edge enter IDLE and clear every output, latched op/shamt and both flags to 0, including mid-operation.
REQ-032 SHALL give rst priority over start in the same cycle.

Structure
REQ-033 SHALL place op encodings (ADD/SUB/SHL/CMP) and state encodings in a shared include of localparams used by sequencer and decoder.
REQ-034 SHALL be a single module with no sub-modules; instantiated alongside alu with direct port-name wiring.

Verification
REQ-035 SHALL cover ADD: A=0x05, B=0x03, start/op=00 -> done at cycle 4, bus 0x08, dst_we=1, carry_flag=0, zero_flag=0.
REQ-036 SHALL cover SUB: A=0x03, B=0x03 -> bus 0x00, zero_flag=1, carry_flag=1 (no borrow).
REQ-037 SHALL cover SHL: A=0x81, shamt=1 -> LOAD_B skipped, done at cycle 3, bus 0x02, carry_flag=1.
REQ-038 SHALL cover CMP: A=0x02, B=0x05 -> dst_we stays 0, carry_flag=0, zero_flag=0.
REQ-039 SHALL cover start held high through an ADD -> exactly one op runs, second accepted in cycle after done.
REQ-040 SHALL cover rst in EXEC -> next cycle IDLE, all outputs 0, no done pulse.
